// File: rtl/demux_pkg.sv
// Shared types and constants for the registered 1-to-2 demultiplexer.
package demux_pkg;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

   localparam logic SEL_OUT1 = 1'b0;
   localparam logic SEL_OUT2 = 1'b1;

   localparam int N_DEF  = 32;
   localparam int CW_DEF = 16;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding slot: accepts a word on load, presents it until the consumer drains it.
module demux_slot
   import demux_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [N-1:0] loadData,
   input  logic         ready,
   output logic         valid,
   output logic [N-1:0] data,
   output logic         canLoad
);

   slot_state_t state;
   slot_state_t nextState;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= SLOT_EMPTY;
      end else begin
         state <= nextState;
      end
   end

   // A load wins over a drain, so a simultaneous drain and load stays FULL without a bubble.
   always_comb begin
      nextState = state;
      if (load) begin
         nextState = SLOT_FULL;
      end else if ((state == SLOT_FULL) && ready) begin
         nextState = SLOT_EMPTY;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data <= '0;
      end else if (load) begin
         data <= loadData;
      end
   end

   assign valid   = (state == SLOT_FULL);
   assign canLoad = !valid || ready;

endmodule

// File: rtl/demux1to2_reg.sv
// Registered 1-to-2 demultiplexer with per-output holding slots.
// Define DEMUX_STATS_EN to add the per-output delivered-word counters count1/count2.
module demux1to2_reg
   import demux_pkg::*;
#(
   parameter int n  = N_DEF,
   parameter int CW = CW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          select,
   input  logic [n-1:0]  dataIn,
   input  logic          inValid,
   output logic          inReady,
   output logic [n-1:0]  data1,
   output logic          valid1,
   input  logic          ready1,
   output logic [n-1:0]  data2,
   output logic          valid2,
   input  logic          ready2
`ifdef DEMUX_STATS_EN
   ,
   output logic [CW-1:0] count1,
   output logic [CW-1:0] count2
`endif
);

   logic canLoad1;
   logic canLoad2;
   logic accept;
   logic load1;
   logic load2;

   // Only the targeted slot gates the producer; the other slot keeps draining on its own.
   assign inReady = !rst && ((select == SEL_OUT2) ? canLoad2 : canLoad1);
   assign accept  = inValid && inReady;
   assign load1   = accept && (select == SEL_OUT1);
   assign load2   = accept && (select == SEL_OUT2);

   demux_slot #(.N(n)) slot1 (
      .clk      (clk),
      .rst      (rst),
      .load     (load1),
      .loadData (dataIn),
      .ready    (ready1),
      .valid    (valid1),
      .data     (data1),
      .canLoad  (canLoad1)
   );

   demux_slot #(.N(n)) slot2 (
      .clk      (clk),
      .rst      (rst),
      .load     (load2),
      .loadData (dataIn),
      .ready    (ready2),
      .valid    (valid2),
      .data     (data2),
      .canLoad  (canLoad2)
   );

`ifdef DEMUX_STATS_EN
   // Counters wrap naturally at their width.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count1 <= '0;
         count2 <= '0;
      end else begin
         if (valid1 && ready1) begin
            count1 <= count1 + 1'b1;
         end
         if (valid2 && ready2) begin
            count2 <= count2 + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_demux1to2_reg.sv
// Directed self-checking bench for demux1to2_reg; stats checks run when DEMUX_STATS_EN is defined.
module tb_demux1to2_reg;

   logic        clk;
   logic        rst;
   logic        select;
   logic [31:0] dataIn;
   logic        inValid;
   logic        inReady;
   logic [31:0] data1;
   logic        valid1;
   logic        ready1;
   logic [31:0] data2;
   logic        valid2;
   logic        ready2;
`ifdef DEMUX_STATS_EN
   logic [15:0] count1;
   logic [15:0] count2;
`endif

   int checks = 0;
   int errors = 0;

   demux1to2_reg dut (
      .clk     (clk),
      .rst     (rst),
      .select  (select),
      .dataIn  (dataIn),
      .inValid (inValid),
      .inReady (inReady),
      .data1   (data1),
      .valid1  (valid1),
      .ready1  (ready1),
      .data2   (data2),
      .valid2  (valid2),
      .ready2  (ready2)
`ifdef DEMUX_STATS_EN
      ,
      .count1  (count1),
      .count2  (count2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // An unknown routing bit on a presented beat is illegal stimulus.
   always @(posedge clk) begin
      if (!rst && inValid) begin
         assert (!$isunknown(select)) else $error("[TB] select unknown while inValid high");
      end
   end

   // Inputs change and outputs are sampled on the falling edge, away from the active edge.
   task automatic step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      ready1 = 1'b0; ready2 = 1'b1;
      select = 1'b0; dataIn = 32'hDEADBEEF; inValid = 1'b1;
      step();
      inValid = 1'b0;
      checks++;
      if (valid1 !== 1'b1 || data1 !== 32'hDEADBEEF) begin
         errors++;
         $display("[TB] FAIL reset_preload: valid1=%b data1=%h expected 1 deadbeef", valid1, data1);
      end
      inValid = 1'b1; dataIn = 32'h11111111;
      #2 rst = 1'b1;
      #1;
      checks++;
      if (valid1 !== 1'b0 || valid2 !== 1'b0 || data1 !== 32'h0 || data2 !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_async: v1=%b v2=%b d1=%h d2=%h expected all 0", valid1, valid2, data1, data2);
      end
      checks++;
      if (inReady !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_inready: got %b expected 0", inReady);
      end
      step();
      checks++;
      if (inReady !== 1'b0 || valid1 !== 1'b0 || data1 !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_hold: inReady=%b valid1=%b data1=%h expected 0 0 0", inReady, valid1, data1);
      end
      inValid = 1'b0;
      rst = 1'b0;
      step();
   endtask

   task automatic test_routing();
      ready1 = 1'b1; ready2 = 1'b1;
      select = 1'b0; dataIn = 32'h5; inValid = 1'b1;
      #1;
      checks++;
      if (inReady !== 1'b1) begin
         errors++;
         $display("[TB] FAIL route_inready: got %b expected 1", inReady);
      end
      step();
      select = 1'b1; dataIn = 32'h3;
      checks++;
      if (valid1 !== 1'b1 || data1 !== 32'h5 || valid2 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL route_out1: v1=%b d1=%h v2=%b expected 1 00000005 0", valid1, data1, valid2);
      end
      step();
      inValid = 1'b0;
      checks++;
      if (valid2 !== 1'b1 || data2 !== 32'h3 || valid1 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL route_out2: v2=%b d2=%h v1=%b expected 1 00000003 0", valid2, data2, valid1);
      end
      step();
   endtask

   task automatic test_backpressure();
      ready1 = 1'b0; ready2 = 1'b1;
      select = 1'b0; dataIn = 32'h7; inValid = 1'b1;
      step();
      dataIn = 32'h8;
      #1;
      checks++;
      if (inReady !== 1'b0 || valid1 !== 1'b1 || data1 !== 32'h7) begin
         errors++;
         $display("[TB] FAIL bp_stall: inReady=%b v1=%b d1=%h expected 0 1 00000007", inReady, valid1, data1);
      end
      step();
      checks++;
      if (data1 !== 32'h7 || valid1 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL bp_hold: v1=%b d1=%h expected 1 00000007", valid1, data1);
      end
      ready1 = 1'b1;
      #1;
      checks++;
      if (inReady !== 1'b1) begin
         errors++;
         $display("[TB] FAIL bp_release_ready: got %b expected 1", inReady);
      end
      step();
      inValid = 1'b0;
      checks++;
      if (valid1 !== 1'b1 || data1 !== 32'h8) begin
         errors++;
         $display("[TB] FAIL bp_replace: v1=%b d1=%h expected 1 00000008", valid1, data1);
      end
   endtask

   // Slot 1 still holds 8 from the back-pressure scenario and is stalled here.
   task automatic test_independence();
      ready1 = 1'b0; ready2 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         select = 1'b1; dataIn = i; inValid = 1'b1;
         #1;
         checks++;
         if (inReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL indep_inready[%0d]: got %b expected 1", i, inReady);
         end
         step();
         checks++;
         if (valid2 !== 1'b1 || data2 !== i) begin
            errors++;
            $display("[TB] FAIL indep_out2[%0d]: v2=%b d2=%h expected 1 %h", i, valid2, data2, i);
         end
      end
      inValid = 1'b0;
      checks++;
      if (valid1 !== 1'b1 || data1 !== 32'h8) begin
         errors++;
         $display("[TB] FAIL indep_slot1: v1=%b d1=%h expected 1 00000008", valid1, data1);
      end
      ready1 = 1'b1;
      step();
   endtask

   task automatic test_back_to_back();
      logic [2:0] tVect;
      ready1 = 1'b1; ready2 = 1'b1;
      for (int t = 0; t < 8; t++) begin
         tVect = t[2:0];
         select = tVect[0]; dataIn = t; inValid = 1'b1;
         #1;
         checks++;
         if (inReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_inready[%0d]: got %b expected 1", t, inReady);
         end
         step();
         checks++;
         if (tVect[0] == 1'b0) begin
            if (valid1 !== 1'b1 || data1 !== t || valid2 !== 1'b0) begin
               errors++;
               $display("[TB] FAIL b2b_out1[%0d]: v1=%b d1=%h v2=%b expected 1 %h 0", t, valid1, data1, valid2, t);
            end
         end else begin
            if (valid2 !== 1'b1 || data2 !== t || valid1 !== 1'b0) begin
               errors++;
               $display("[TB] FAIL b2b_out2[%0d]: v2=%b d2=%h v1=%b expected 1 %h 0", t, valid2, data2, valid1, t);
            end
         end
      end
      inValid = 1'b0;
      step();
   endtask

`ifdef DEMUX_STATS_EN
   task automatic test_stats();
      logic [7:0] pattern;
      pattern = 8'b1011_0110;
      #2 rst = 1'b1;
      #1;
      checks++;
      if (count1 !== 16'h0 || count2 !== 16'h0) begin
         errors++;
         $display("[TB] FAIL stats_reset: count1=%0d count2=%0d expected 0 0", count1, count2);
      end
      rst = 1'b0;
      step();
      ready1 = 1'b1; ready2 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         select = pattern[i]; dataIn = 32'h100 + i; inValid = 1'b1;
         step();
      end
      inValid = 1'b0;
      step();
      checks++;
      if (count1 !== 16'd3 || count2 !== 16'd5) begin
         errors++;
         $display("[TB] FAIL stats_count: count1=%0d count2=%0d expected 3 5", count1, count2);
      end
      #2 rst = 1'b1;
      #1 rst = 1'b0;
      step();
      select = 1'b0; dataIn = 32'hA5; inValid = 1'b1;
      for (int i = 0; i < 65535; i++) begin
         step();
      end
      inValid = 1'b0;
      step();
      checks++;
      if (count1 !== 16'hFFFF) begin
         errors++;
         $display("[TB] FAIL stats_preload: count1=%h expected ffff", count1);
      end
      inValid = 1'b1;
      step();
      inValid = 1'b0;
      step();
      checks++;
      if (count1 !== 16'h0 || count2 !== 16'h0) begin
         errors++;
         $display("[TB] FAIL stats_wrap: count1=%h count2=%h expected 0000 0000", count1, count2);
      end
   endtask
`endif

   initial begin
      rst = 1'b1;
      select = 1'b0; dataIn = '0; inValid = 1'b0;
      ready1 = 1'b0; ready2 = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();
      test_reset();
      test_routing();
      test_backpressure();
      test_independence();
      test_back_to_back();
`ifdef DEMUX_STATS_EN
      test_stats();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
